// File: rtl/matrix_scan_controller.sv
// Row-scanning LED matrix scheduler with anti-ghost blanking, per-frame image latch and image alternation.
// Optional lamp test input and override are enabled by defining SCAN_LAMP_TEST_EN.
module matrix_scan_controller #(
  parameter int unsigned NUM_ROWS         = 7,
  parameter int unsigned NUM_COLS         = 5,
  parameter int unsigned ROW_TICKS        = 65536,
  parameter int unsigned BLANK_TICKS      = 64,
  parameter int unsigned FRAMES_PER_IMAGE = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         hold_image,
`ifdef SCAN_LAMP_TEST_EN
  input  logic                         lamp_test,
`endif
  input  logic [NUM_ROWS*NUM_COLS-1:0] img0_data,
  input  logic [NUM_ROWS*NUM_COLS-1:0] img1_data,
  output logic [2:0]                   row_sel,
  output logic [NUM_ROWS-1:0]          row_en_n,
  output logic [NUM_COLS-1:0]          col_data,
  output logic                         image_sel,
  output logic                         frame_start
);

  localparam int unsigned SW = $clog2(ROW_TICKS);
  localparam int unsigned FW = $clog2(FRAMES_PER_IMAGE) + 1;
  localparam int unsigned DW = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state;
  logic [SW-1:0] slot_cnt;
  logic [2:0]    row;
  logic [FW-1:0] frame_cnt;
  logic [DW-1:0] frame_buf;

  logic                slot_last;
  logic                row_last;
  logic                frame_end;
  logic                drive_nxt;
  logic [SW-1:0]       slot_nxt;
  logic [2:0]          row_nxt;
  logic                img_nxt;
  logic [FW-1:0]       fcnt_nxt;
  logic [NUM_ROWS-1:0] row_dec;
  logic [NUM_COLS-1:0] drive_cols;

  // Slot/row/frame sequencing for the cycle that follows the next edge.
  always_comb begin
    slot_last  = (slot_cnt == SW'(ROW_TICKS - 1));
    row_last   = (row == 3'(NUM_ROWS - 1));
    frame_end  = slot_last && row_last;
    slot_nxt   = slot_last ? '0 : slot_cnt + SW'(1);
    row_nxt    = row;
    if (slot_last) row_nxt = row_last ? 3'd0 : row + 3'd1;
    drive_nxt  = (slot_nxt >= SW'(BLANK_TICKS));

    img_nxt  = image_sel;
    fcnt_nxt = frame_cnt;
    if (frame_end && !hold_image) begin
      if (frame_cnt == FW'(FRAMES_PER_IMAGE - 1)) begin
        img_nxt  = ~image_sel;
        fcnt_nxt = '0;
      end else begin
        fcnt_nxt = frame_cnt + FW'(1);
      end
    end

    row_dec    = '0;
    drive_cols = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_nxt == 3'(r)) begin
        row_dec[r] = 1'b1;
        drive_cols = frame_buf[r*NUM_COLS +: NUM_COLS];
      end
    end
`ifdef SCAN_LAMP_TEST_EN
    if (lamp_test) drive_cols = '1;
`endif
  end

  // Scan FSM; all outputs are registered from the next-cycle values above.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      slot_cnt    <= '0;
      row         <= '0;
      frame_cnt   <= '0;
      frame_buf   <= '0;
      row_sel     <= '0;
      row_en_n    <= '1;
      col_data    <= '0;
      image_sel   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        slot_cnt <= '0;
        row      <= '0;
        row_sel  <= '0;
        row_en_n <= '1;
        col_data <= '0;
      end else if (state == IDLE) begin
        state       <= BLANK;
        slot_cnt    <= '0;
        row         <= '0;
        row_sel     <= '0;
        row_en_n    <= '1;
        col_data    <= '0;
        frame_buf   <= image_sel ? img1_data : img0_data;
        frame_start <= 1'b1;
      end else begin
        slot_cnt  <= slot_nxt;
        row       <= row_nxt;
        row_sel   <= row_nxt;
        image_sel <= img_nxt;
        frame_cnt <= fcnt_nxt;
        if (frame_end) begin
          // Relatch uses the post-toggle image so the new frame shows the new image.
          frame_buf   <= img_nxt ? img1_data : img0_data;
          frame_start <= 1'b1;
        end
        if (drive_nxt) begin
          state    <= DRIVE;
          row_en_n <= ~row_dec;
          col_data <= drive_cols;
        end else begin
          state    <= BLANK;
          row_en_n <= '1;
          col_data <= '0;
        end
      end
    end
  end

endmodule
